// File: rtl/kangaroo_video_pkg.sv
// Shared types and defaults for the video read-side pixel path.
package kangaroo_video_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/video_sync_delay_line.sv
// Fixed-depth delay line for an active-low sync; reset fills it with 1 (inactive).
module video_sync_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  generate
    if (DEPTH == 1) begin : g_single
      logic stage;
      always_ff @(posedge clk) begin
        if (reset) stage <= 1'b1;
        else       stage <= din;
      end
      assign dout = stage;
    end else begin : g_chain
      logic [DEPTH-1:0] chain;
      always_ff @(posedge clk) begin
        if (reset) chain <= '1;
        else       chain <= {chain[DEPTH-2:0], din};
      end
      assign dout = chain[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_pixel_shift_and_blank.sv
// Double-buffered VRAM byte serialiser with blanking, VSYNC realignment and under/overrun flags.
// Optional inverse video is compiled in when VIDEO_INVERSE_EN is defined.
module video_pixel_shift_and_blank
  import kangaroo_video_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SYNC_DELAY = 2,
  parameter int FRAME_W    = 6
) (
  input  logic                  CLOCK_10MHZ,
  input  logic                  RESET,
  input  logic                  LD_SFT_AL,
  input  logic                  SFT_AL,
  input  logic [DATA_WIDTH-1:0] VRAM_DATA,
  input  logic                  BLANK_AL,
  input  logic                  VSYNC_AL,
  input  logic                  INVERT,
  input  logic                  STATUS_CLR,
  output logic                  VIDEO_OUT,
  output logic                  VSYNC_OUT_AL,
  output logic [FRAME_W-1:0]    FRAME_COUNT,
  output logic                  UNDERRUN,
  output logic                  OVERRUN
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  state_t                state, state_next;
  logic                  ld_q, vs_q, blank_q;
  logic [DATA_WIDTH-1:0] hold, shift_reg;
  logic                  hold_full;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  pix;
  logic [FRAME_W-1:0]    frame_count;
  logic                  underrun_q, overrun_q;

  logic load_evt, vs_fall, tick, transfer, underrun_set, overrun_set;
  logic xfer_bit, shift_bit;

  assign load_evt     = ld_q & ~LD_SFT_AL;
  assign vs_fall      = vs_q & ~VSYNC_AL;
  assign tick         = ~SFT_AL;
  assign transfer     = tick & (bit_cnt == '0) & hold_full & ~vs_fall;
  assign underrun_set = tick & (bit_cnt == '0) & ~hold_full & ~vs_fall & (state == ST_RUN);
  assign overrun_set  = load_evt & hold_full & ~transfer & ~vs_fall;

`ifdef VIDEO_INVERSE_EN
  // Inversion is latched per byte at transfer so a mid-byte INVERT change waits for the next byte.
  logic inv_q;

  always_ff @(posedge CLOCK_10MHZ) begin
    if (RESET)         inv_q <= 1'b0;
    else if (transfer) inv_q <= INVERT;
  end

  always_comb begin
    xfer_bit  = hold[DATA_WIDTH-1] ^ INVERT;
    shift_bit = shift_reg[DATA_WIDTH-1] ^ inv_q;
  end
`else
  logic unused_invert;
  assign unused_invert = INVERT;

  always_comb begin
    xfer_bit  = hold[DATA_WIDTH-1];
    shift_bit = shift_reg[DATA_WIDTH-1];
  end
`endif

  always_ff @(posedge CLOCK_10MHZ) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (vs_fall)                            state_next = ST_IDLE;
    else if (state == ST_IDLE && load_evt)  state_next = ST_RUN;
  end

  // A VSYNC falling edge flushes the pipeline and swallows any load or tick in that cycle.
  always_ff @(posedge CLOCK_10MHZ) begin
    if (RESET) begin
      ld_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      hold        <= '0;
      shift_reg   <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      pix         <= 1'b0;
      frame_count <= '0;
    end else begin
      ld_q    <= LD_SFT_AL;
      vs_q    <= VSYNC_AL;
      blank_q <= BLANK_AL;
      if (vs_fall) begin
        hold_full   <= 1'b0;
        bit_cnt     <= '0;
        frame_count <= frame_count + 1'b1;
      end else begin
        if (tick) begin
          if (bit_cnt != '0) begin
            pix       <= shift_bit;
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt - 1'b1;
          end else if (hold_full) begin
            pix       <= xfer_bit;
            shift_reg <= hold << 1;
            bit_cnt   <= CNT_W'(DATA_WIDTH - 1);
          end else begin
            pix <= 1'b0;
          end
        end
        if (load_evt) begin
          hold      <= VRAM_DATA;
          hold_full <= 1'b1;
        end else if (transfer) begin
          hold_full <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_10MHZ) begin
    if (RESET) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      underrun_q <= STATUS_CLR ? 1'b0 : (underrun_q | underrun_set);
      overrun_q  <= STATUS_CLR ? 1'b0 : (overrun_q | overrun_set);
    end
  end

  video_sync_delay_line #(
    .DEPTH (SYNC_DELAY)
  ) u_vsync_delay (
    .clk   (CLOCK_10MHZ),
    .reset (RESET),
    .din   (VSYNC_AL),
    .dout  (VSYNC_OUT_AL)
  );

  assign VIDEO_OUT   = pix & blank_q;
  assign FRAME_COUNT = frame_count;
  assign UNDERRUN    = underrun_q;
  assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_video_pixel_shift_and_blank.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based pixel model.
module tb_video_pixel_shift_and_blank;

  localparam int DW = 8;
  localparam int SD = 2;
  localparam int FW = 6;

  logic          CLOCK_10MHZ = 1'b0;
  logic          RESET, LD_SFT_AL, SFT_AL, BLANK_AL, VSYNC_AL, INVERT, STATUS_CLR;
  logic [DW-1:0] VRAM_DATA;
  logic          VIDEO_OUT, VSYNC_OUT_AL, UNDERRUN, OVERRUN;
  logic [FW-1:0] FRAME_COUNT;

  int compared   = 0;
  int mismatched = 0;

  video_pixel_shift_and_blank #(
    .DATA_WIDTH (DW),
    .SYNC_DELAY (SD),
    .FRAME_W    (FW)
  ) dut (
    .CLOCK_10MHZ  (CLOCK_10MHZ),
    .RESET        (RESET),
    .LD_SFT_AL    (LD_SFT_AL),
    .SFT_AL       (SFT_AL),
    .VRAM_DATA    (VRAM_DATA),
    .BLANK_AL     (BLANK_AL),
    .VSYNC_AL     (VSYNC_AL),
    .INVERT       (INVERT),
    .STATUS_CLR   (STATUS_CLR),
    .VIDEO_OUT    (VIDEO_OUT),
    .VSYNC_OUT_AL (VSYNC_OUT_AL),
    .FRAME_COUNT  (FRAME_COUNT),
    .UNDERRUN     (UNDERRUN),
    .OVERRUN      (OVERRUN)
  );

  always #50 CLOCK_10MHZ = ~CLOCK_10MHZ;

  // Reference model: pending pixels live in a queue, the hold register is a byte plus a valid bit.
  bit          m_ld_prev, m_vs_prev, m_run, m_hold_full, m_pix, m_blank, m_under, m_over;
  logic [DW-1:0] m_hold;
  int          m_frame;
  bit          m_q[$];
  bit          m_vs_hist[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_ld_prev = 1; m_vs_prev = 1; m_run = 0; m_hold_full = 0; m_hold = '0;
    m_pix = 0; m_blank = 0; m_under = 0; m_over = 0; m_frame = 0;
    m_q.delete();
    m_vs_hist.delete();
    for (int i = 0; i < SD; i++) m_vs_hist.push_back(1'b1);
  endtask

  task automatic modelEdge();
    bit load, vsf, set_u, set_o;
    if (RESET) begin
      modelReset();
      return;
    end
    load  = m_ld_prev && !LD_SFT_AL;
    vsf   = m_vs_prev && !VSYNC_AL;
    set_u = 0;
    set_o = 0;
    if (vsf) begin
      m_hold_full = 0;
      m_q.delete();
      m_run = 0;
      m_frame = (m_frame + 1) % (1 << FW);
    end else begin
      if (!SFT_AL) begin
        if (m_q.size() > 0) begin
          m_pix = m_q.pop_front();
        end else if (m_hold_full) begin
          for (int b = DW - 1; b >= 0; b--) begin
`ifdef VIDEO_INVERSE_EN
            m_q.push_back(m_hold[b] ^ INVERT);
`else
            m_q.push_back(m_hold[b]);
`endif
          end
          m_pix = m_q.pop_front();
          m_hold_full = 0;
        end else begin
          m_pix = 0;
          if (m_run) set_u = 1;
        end
      end
      if (load) begin
        if (m_hold_full) set_o = 1;
        m_hold = VRAM_DATA;
        m_hold_full = 1;
        m_run = 1;
      end
    end
    m_under = STATUS_CLR ? 1'b0 : (m_under | set_u);
    m_over  = STATUS_CLR ? 1'b0 : (m_over | set_o);
    m_blank = BLANK_AL;
    m_ld_prev = LD_SFT_AL;
    m_vs_prev = VSYNC_AL;
    m_vs_hist.push_back(VSYNC_AL);
    if (m_vs_hist.size() > SD) void'(m_vs_hist.pop_front());
  endtask

  task automatic step();
    @(posedge CLOCK_10MHZ);
    modelEdge();
    @(negedge CLOCK_10MHZ);
    checkOutput("video",    32'(VIDEO_OUT),    32'(m_pix & m_blank));
    checkOutput("vsync",    32'(VSYNC_OUT_AL), 32'(m_vs_hist[0]));
    checkOutput("frame",    32'(FRAME_COUNT),  32'(m_frame));
    checkOutput("underrun", 32'(UNDERRUN),     32'(m_under));
    checkOutput("overrun",  32'(OVERRUN),      32'(m_over));
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic sft, input logic [DW-1:0] data,
                               input logic blank, input logic vs, input logic clr, input logic inv);
    RESET = rst; LD_SFT_AL = ld; SFT_AL = sft; VRAM_DATA = data;
    BLANK_AL = blank; VSYNC_AL = vs; STATUS_CLR = clr; INVERT = inv;
    step();
  endtask

  task automatic doReset();
    applyStimulus(1, 1, 1, '0, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, '0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, '0, 1, 1, 0, 0);
  endtask

  logic [7:0]  pat;
  logic [15:0] seq;

  initial begin
    RESET = 1; LD_SFT_AL = 1; SFT_AL = 1; VRAM_DATA = '0;
    BLANK_AL = 1; VSYNC_AL = 1; STATUS_CLR = 0; INVERT = 0;
    modelReset();

    doReset();
    checkOutput("rst_vsync", 32'(VSYNC_OUT_AL), 32'd1);
    checkOutput("rst_frame", 32'(FRAME_COUNT), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, '0, 1, 1, 0, 0);
      checkOutput("idle_video", 32'(VIDEO_OUT), 32'd0);
      checkOutput("idle_under", 32'(UNDERRUN), 32'd0);
    end

    doReset();
    pat = 8'hA5;
    applyStimulus(0, 0, 1, pat, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 0, '0, 1, 1, 0, 0);
      checkOutput("a5_bit", 32'(VIDEO_OUT), 32'(pat[7-i]));
      applyStimulus(0, 1, 1, '0, 1, 1, 0, 0);
    end

    doReset();
    seq = 16'hFF0F;
    applyStimulus(0, 0, 1, 8'hFF, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, (i == 2) ? 1'b0 : 1'b1, 0, (i == 2) ? 8'h0F : 8'h00, 1, 1, 0, 0);
      checkOutput("seam_bit", 32'(VIDEO_OUT), 32'(seq[15-i]));
    end
    checkOutput("seam_under", 32'(UNDERRUN), 32'd0);
    checkOutput("seam_over",  32'(OVERRUN),  32'd0);

    doReset();
    pat = 8'h42;
    applyStimulus(0, 0, 1, 8'h81, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 8'h00, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 8'h42, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 8'h00, 1, 1, 0, 0);
    checkOutput("ovr_set", 32'(OVERRUN), 32'd1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 0, '0, 1, 1, 0, 0);
      checkOutput("ovr_bit", 32'(VIDEO_OUT), 32'(pat[7-i]));
      applyStimulus(0, 1, 1, '0, 1, 1, 0, 0);
    end
    checkOutput("pre_under", 32'(UNDERRUN), 32'd0);
    applyStimulus(0, 1, 0, '0, 1, 1, 0, 0);
    checkOutput("under_set", 32'(UNDERRUN), 32'd1);
    applyStimulus(0, 1, 1, '0, 1, 1, 1, 0);
    checkOutput("clr_under", 32'(UNDERRUN), 32'd0);
    checkOutput("clr_over",  32'(OVERRUN),  32'd0);

    doReset();
    applyStimulus(0, 0, 1, 8'hFF, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 0, '0, 0, 1, 0, 0);
      checkOutput("blank_video", 32'(VIDEO_OUT), 32'd0);
    end

    doReset();
    applyStimulus(0, 1, 1, '0, 1, 0, 0, 0);
    checkOutput("vs_frame1", 32'(FRAME_COUNT), 32'd1);
    checkOutput("vs_early", 32'(VSYNC_OUT_AL), 32'd1);
    applyStimulus(0, 1, 1, '0, 1, 1, 0, 0);
    checkOutput("vs_delayed", 32'(VSYNC_OUT_AL), 32'd0);
    applyStimulus(0, 1, 1, '0, 1, 1, 0, 0);
    checkOutput("vs_release", 32'(VSYNC_OUT_AL), 32'd1);
    for (int i = 0; i < 62; i++) begin
      applyStimulus(0, 1, 1, '0, 1, 0, 0, 0);
      applyStimulus(0, 1, 1, '0, 1, 1, 0, 0);
    end
    checkOutput("frame_max", 32'(FRAME_COUNT), 32'd63);
    applyStimulus(0, 1, 1, '0, 1, 0, 0, 0);
    checkOutput("frame_wrap", 32'(FRAME_COUNT), 32'd0);

`ifdef VIDEO_INVERSE_EN
    doReset();
    pat = 8'h0F;
    applyStimulus(0, 0, 1, 8'hF0, 1, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 0, '0, 1, 1, 0, 1);
      checkOutput("inv_bit", 32'(VIDEO_OUT), 32'(pat[7-i]));
    end
`endif

    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 500) == 0,
                    ($urandom % 6) != 0,
                    ($urandom % 3) != 0,
                    DW'($urandom),
                    ($urandom % 8) != 0,
                    ($urandom % 100) != 0,
                    ($urandom % 40) == 0,
                    1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
